// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Round-robin arbiter guarding a single shared W-bit register. Each grant
//   takes two cycles: one BUSY cycle owning the bank, then the operation is
//   applied and acknowledged as the FSM drops back to IDLE.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   req   : [N-1:0]   per-requester access request
//   op    : [2N-1:0]  per-requester op (00 LOAD, 01 TOGGLE, 10 CLEAR, 11 HOLD)
//   data  : [W*N-1:0] per-requester operand
//   gnt   : [N-1:0]   one-hot owner of the bank during BUSY
//   ack   : [N-1:0]   one-cycle completion pulse
//   q     : [W-1:0]   shared register contents
//   busy  : high while the FSM is in BUSY
module reg_bank_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [2*N-1:0]   op,
    input  logic [W*N-1:0]   data,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
    output logic [W-1:0]     q,
    output logic             busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    logic [0:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] pick_idx;
    logic          pick_valid;
    logic [N-1:0]  eligible;
    logic [1:0]    win_op;
    logic [W-1:0]  win_data;
    logic [W-1:0]  q_next;
    logic [PW-1:0] ptr_next;

    // A requester whose ack is showing this cycle is masked, so a requester
    // that only drops req one cycle after its ack is not served twice.
    always_comb begin
        eligible = req & ~ack;
    end

    // Round-robin search starting at ptr and wrapping past N-1 back to 0.
    // The sum is kept one bit wider so a non-power-of-two N wraps correctly.
    always_comb begin
        logic [PW:0] sum;
        pick_valid = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            if (!pick_valid && eligible[sum[PW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = sum[PW-1:0];
            end
        end
    end

    // Pick out the current owner's op and operand; sampled when BUSY ends.
    always_comb begin
        win_op   = '0;
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (win_idx == PW'(i)) begin
                win_op   = op[2*i +: 2];
                win_data = data[W*i +: W];
            end
        end
    end

    // Register update for the owner's operation; HOLD keeps q as it is.
    always_comb begin
        case (win_op)
            OP_LOAD:   q_next = win_data;
            OP_TOGGLE: q_next = q ^ win_data;
            OP_CLEAR:  q_next = '0;
            default:   q_next = q;
        endcase
    end

    // Priority moves to the requester just after the one served.
    always_comb begin
        if (win_idx == PW'(N - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_idx + PW'(1);
        end
    end

    // Two-state FSM. Reset aborts any operation in flight without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            ack     <= '0;
            q       <= '0;
            ptr     <= '0;
            win_idx <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= BUSY;
                        gnt     <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                        win_idx <= pick_idx;
                    end
                end
                BUSY: begin
                    state <= IDLE;
                    gnt   <= '0;
                    ack   <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                    q     <= q_next;
                    ptr   <= ptr_next;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
//   Directed bench for reg_bank_arbiter (N=4, W=8). Stimulus queues the
//   expected grants and acks; a monitor forked alongside pops and compares
//   them whenever the DUT shows a grant or an ack.
module tb_reg_bank_arbiter;

    localparam logic [1:0] LOAD   = 2'b00;
    localparam logic [1:0] TOGGLE = 2'b01;
    localparam logic [1:0] CLEAR  = 2'b10;
    localparam logic [1:0] HOLD   = 2'b11;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] q;
        int         gap;
    } ack_item_t;

    logic [3:0] gnt_q[$];
    ack_item_t  ack_q[$];

    int checks;
    int errors;
    int cyc;
    int last_ack_cyc;

    reg_bank_arbiter #(.N(4), .W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .op   (op),
        .data (data),
        .gnt  (gnt),
        .ack  (ack),
        .q    (q),
        .busy (busy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushGnt(input logic [3:0] g);
        gnt_q.push_back(g);
    endtask

    task automatic pushAck(input logic [3:0] a, input logic [7:0] qv, input int gap);
        ack_item_t item;
        item.ack = a;
        item.q   = qv;
        item.gap = gap;
        ack_q.push_back(item);
    endtask

    task automatic drive(input logic [3:0] rv, input logic [7:0] ov, input logic [31:0] dv);
        req  = rv;
        op   = ov;
        data = dv;
    endtask

    // One complete transaction from a single requester: raise req, hold it
    // until the ack edge, drop it, then leave one quiet cycle.
    task automatic applyStimulus(input logic [1:0] idx, input logic [1:0] opv,
                                 input logic [7:0] dv, input logic [7:0] expq);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        pushGnt(onehot);
        pushAck(onehot, expq, 0);
        drive(onehot, {6'b0, opv} << {idx, 1'b0}, {24'b0, dv} << {idx, 3'b000});
        tick(2);
        drive(4'b0000, 8'h00, 32'h0);
        tick(1);
    endtask

    // Scoreboard consumer: every grant and ack the DUT shows must match the
    // next queued expectation; anything shown with nothing queued is a fault.
    task automatic monitorLoop();
        logic [3:0] exp_g;
        ack_item_t  item;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (gnt != 4'b0000) begin
                    if (gnt_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_gnt actual=%b required=none", gnt);
                    end else begin
                        exp_g = gnt_q.pop_front();
                        checkOutput("gnt", 32'(gnt), 32'(exp_g));
                        checkOutput("busy_during_grant", 32'(busy), 32'd1);
                    end
                end
                if (ack != 4'b0000) begin
                    if (ack_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_ack actual=%b q=0x%0h required=none", ack, q);
                    end else begin
                        item = ack_q.pop_front();
                        checkOutput("ack", 32'(ack), 32'(item.ack));
                        checkOutput("q_at_ack", 32'(q), 32'(item.q));
                        checkOutput("busy_at_ack", 32'(busy), 32'd0);
                        if (item.gap != 0) begin
                            checkOutput("ack_spacing", 32'(cyc - last_ack_cyc), 32'(item.gap));
                        end
                    end
                    last_ack_cyc = cyc;
                end
            end
        end
    endtask

    // Main sequence: reset checks, single-requester ops, round-robin
    // fairness, ack masking, and reset aborting a BUSY cycle.
    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        last_ack_cyc = 0;
        rst          = 1'b1;
        drive(4'b0000, 8'h00, 32'h0);

        fork
            monitorLoop();
        join_none

        // Reset state, held across a few clock edges.
        tick(3);
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_ack", 32'(ack), 32'd0);
        checkOutput("reset_q", 32'(q), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(1);

        // LOAD, TOGGLE twice, then LOAD/CLEAR/LOAD/HOLD.
        $display("[TB] single requester operations");
        applyStimulus(2'd0, LOAD,   8'hA5, 8'hA5);
        applyStimulus(2'd1, TOGGLE, 8'h0F, 8'hAA);
        applyStimulus(2'd1, TOGGLE, 8'h0F, 8'hA5);
        applyStimulus(2'd0, LOAD,   8'h3C, 8'h3C);
        applyStimulus(2'd0, CLEAR,  8'h77, 8'h00);
        applyStimulus(2'd0, LOAD,   8'h3C, 8'h3C);
        applyStimulus(2'd0, HOLD,   8'hFF, 8'h3C);

        // Reset while idle clears q and restarts priority at requester 0.
        rst = 1'b1;
        #1;
        checkOutput("idle_reset_q", 32'(q), 32'd0);
        #2;
        rst = 1'b0;
        tick(1);

        // All four requesting continuously: 0,1,2,3,0 with acks 2 cycles apart.
        $display("[TB] round robin with all requesting");
        pushGnt(4'b0001);
        pushGnt(4'b0010);
        pushGnt(4'b0100);
        pushGnt(4'b1000);
        pushGnt(4'b0001);
        pushAck(4'b0001, 8'h11, 0);
        pushAck(4'b0010, 8'h22, 2);
        pushAck(4'b0100, 8'h33, 2);
        pushAck(4'b1000, 8'h44, 2);
        pushAck(4'b0001, 8'h11, 2);
        drive(4'b1111, 8'h00, 32'h44332211);
        tick(10);
        drive(4'b0000, 8'h00, 32'h0);
        tick(2);

        // req2 stays up through its ack cycle while req3 waits: 3 goes next.
        $display("[TB] stale request after ack");
        pushGnt(4'b0100);
        pushGnt(4'b1000);
        pushAck(4'b0100, 8'h77, 0);
        pushAck(4'b1000, 8'h88, 2);
        drive(4'b1100, 8'h00, 32'h88770000);
        tick(3);
        drive(4'b1000, 8'h00, 32'h88000000);
        tick(1);
        drive(4'b0000, 8'h00, 32'h0);
        tick(1);

        // req2 alone held through its ack cycle must not be granted again.
        pushGnt(4'b0100);
        pushAck(4'b0100, 8'h99, 0);
        drive(4'b0100, 8'h00, 32'h00990000);
        tick(3);
        drive(4'b0000, 8'h00, 32'h0);
        tick(2);

        // Reset in the middle of a LOAD of 0xFF: no ack, q cleared.
        $display("[TB] reset during busy");
        pushGnt(4'b0001);
        drive(4'b0001, 8'h00, 32'h000000FF);
        tick(1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_q", 32'(q), 32'd0);
        checkOutput("abort_gnt", 32'(gnt), 32'd0);
        checkOutput("abort_ack", 32'(ack), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        drive(4'b0000, 8'h00, 32'h0);
        #2;
        rst = 1'b0;
        tick(3);
        checkOutput("post_abort_q", 32'(q), 32'd0);

        // First arbitration after reset with req=1010 goes to requester 1.
        pushGnt(4'b0010);
        pushGnt(4'b1000);
        pushAck(4'b0010, 8'h12, 0);
        pushAck(4'b1000, 8'h34, 2);
        drive(4'b1010, 8'h00, 32'h34001200);
        tick(2);
        drive(4'b1000, 8'h00, 32'h34000000);
        tick(2);
        drive(4'b0000, 8'h00, 32'h0);
        tick(3);

        // Every expected grant and ack must have been observed.
        checkOutput("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
        checkOutput("ack_queue_drained", 32'(ack_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
